// File: rtl/id_stage_ctrl_pkg.sv
// Shared definitions for the decode-stage controller: immediate-format codes,
// RV32I major opcodes and the decode-register FSM state encoding.
package id_stage_ctrl_pkg;

    // Immediate-format select codes, shared with the immediate generator
    localparam logic [2:0] IMM_R         = 3'b000;
    localparam logic [2:0] IMM_I_NONSHFT = 3'b001;
    localparam logic [2:0] IMM_I_SHIFT   = 3'b010;
    localparam logic [2:0] IMM_S         = 3'b011;
    localparam logic [2:0] IMM_B         = 3'b100;
    localparam logic [2:0] IMM_U         = 3'b101;
    localparam logic [2:0] IMM_J         = 3'b110;
    localparam logic [2:0] IMM_NONE      = 3'b000;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam logic [2:0] F3_SLLI      = 3'b001;
    localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_RESUME = 2'd2
    } state_e;

endpackage

// File: rtl/id_stage_ctrl_imm_sel_dec.sv
// Combinational opcode/funct3 to immediate-format decode used when the
// decode register captures a new instruction.
module imm_sel_dec
    import id_stage_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output logic [2:0] imm_sel_o
);

    always_comb begin
        imm_sel_o = IMM_NONE;
        case (opcode_i)
            OPC_OP:     imm_sel_o = IMM_R;
            OPC_LOAD:   imm_sel_o = IMM_I_NONSHFT;
            OPC_JALR:   imm_sel_o = IMM_I_NONSHFT;
            OPC_OP_IMM: begin
                // Shift-immediates carry a shamt field rather than a full 12-bit immediate
                if (funct3_i == F3_SLLI || funct3_i == F3_SRLI_SRAI)
                    imm_sel_o = IMM_I_SHIFT;
                else
                    imm_sel_o = IMM_I_NONSHFT;
            end
            OPC_STORE:  imm_sel_o = IMM_S;
            OPC_BRANCH: imm_sel_o = IMM_B;
            OPC_LUI:    imm_sel_o = IMM_U;
            OPC_AUIPC:  imm_sel_o = IMM_U;
            OPC_JAL:    imm_sel_o = IMM_J;
            default:    imm_sel_o = IMM_NONE;
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage pipeline register and control: capture, backpressure, flush and
// load-use bubble insertion. Load-use detection is built only with ID_HAZARD_DETECT_EN.
module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_INST = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_valid_i,
    input  logic [31:0] if_inst_i,
    input  logic [31:0] if_pc_i,
    output logic        if_ready_o,
    input  logic        ex_ready_i,
    input  logic        flush_i,
    input  logic        ex_mem_read_i,
    input  logic [4:0]  ex_rd_i,
    output logic        id_valid_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o,
    output logic [2:0]  imm_sel_o,
    output logic        stall_o,
    output logic [1:0]  dbg_state_o
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never depends on ready, and flush_i cancels any fetch transfer.

    state_e      state_q, state_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  imm_q, imm_d;
    logic [2:0]  dec_imm;
    logic        hazard;
    logic        if_ready;
    logic        id_valid;
    logic        stall;
    logic        capture;

    imm_sel_dec u_imm_sel_dec (
        .opcode_i  (if_inst_i[6:0]),
        .funct3_i  (if_inst_i[14:12]),
        .imm_sel_o (dec_imm)
    );

`ifdef ID_HAZARD_DETECT_EN
    // Only a fresh FULL instruction is checked; RESUME has already paid its bubble
    assign hazard = (state_q == ST_FULL) && ex_mem_read_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == inst_q[19:15]) || (ex_rd_i == inst_q[24:20]));
`else
    logic unused_hazard_in;
    assign hazard           = 1'b0;
    assign unused_hazard_in = ^{ex_mem_read_i, ex_rd_i};
`endif

    always_comb begin
        id_valid = 1'b0;
        if_ready = 1'b0;
        stall    = 1'b0;
        case (state_q)
            ST_EMPTY: if_ready = 1'b1;
            ST_FULL: begin
                if (hazard) begin
                    stall = 1'b1;
                end else begin
                    id_valid = 1'b1;
                    if_ready = ex_ready_i;
                end
            end
            ST_RESUME: begin
                id_valid = 1'b1;
                if_ready = ex_ready_i;
            end
            default: if_ready = 1'b1;
        endcase
    end

    assign capture = if_valid_i && if_ready && !flush_i;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        pc_d    = pc_q;
        imm_d   = imm_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            inst_d  = RESET_INST;
            imm_d   = IMM_NONE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (capture) begin
                        state_d = ST_FULL;
                        inst_d  = if_inst_i;
                        pc_d    = if_pc_i;
                        imm_d   = dec_imm;
                    end
                end
                ST_FULL, ST_RESUME: begin
                    if (stall) begin
                        state_d = ST_RESUME;
                    end else if (ex_ready_i) begin
                        if (capture) begin
                            state_d = ST_FULL;
                            inst_d  = if_inst_i;
                            pc_d    = if_pc_i;
                            imm_d   = dec_imm;
                        end else begin
                            state_d = ST_EMPTY;
                        end
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            inst_q  <= RESET_INST;
            pc_q    <= 32'd0;
            imm_q   <= IMM_NONE;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            pc_q    <= pc_d;
            imm_q   <= imm_d;
        end
    end

    assign if_ready_o  = if_ready;
    assign id_valid_o  = id_valid;
    assign stall_o     = stall;
    assign id_inst_o   = inst_q;
    assign id_pc_o     = pc_q;
    assign imm_sel_o   = imm_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/id_stage_ctrl.md
ID_STAGE_CTRL -- requirements
Module: id_stage_ctrl

Interface
REQ-001 SHALL have parameter RESET_INST, default 32'h0000_0013 (NOP), the value of id_inst_o after reset or flush.
REQ-002 SHALL have ports: clk_i  in  1  clock; all state updates on its rising edge.
REQ-003 SHALL have ports: rst_n_i  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: if_valid_i  in  1  fetch offers an instruction.
REQ-005 SHALL have ports: if_inst_i  in  32  fetched instruction; if_pc_i  in  32  its PC.
REQ-006 SHALL have ports: if_ready_o  out  1  decode register can accept this cycle.
REQ-007 SHALL have ports: ex_ready_i  in  1  execute stage accepts the decode output.
REQ-008 SHALL have ports: flush_i  in  1  taken branch/jump; discard decode contents.
REQ-009 SHALL have ports: ex_mem_read_i  in  1  load in EX; ex_rd_i  in  5  its destination register.
REQ-010 SHALL have ports: id_valid_o  out  1; id_inst_o  out  32; id_pc_o  out  32; imm_sel_o  out  3  immediate-format select for the immediate generator; stall_o  out  1  load-use bubble this cycle.

Function
REQ-011 SHALL capture if_inst_i/if_pc_i and the decoded imm_sel on the edge where if_valid_i && if_ready_o && !flush_i.
REQ-012 SHALL decode imm_sel from the captured opcode: 0110011->R(000); 0000011, 1100111, 0010011 with funct3 not 001/101 -> I_nonshift(001); 0010011 with funct3 001/101 -> I_shift(010); 0100011->S(011); 1100011->B(100); 0110111/0010111->U(101); 1101111->J(110); other->000.
REQ-013 SHALL present imm_sel_o registered, updating on the same edge as id_inst_o (latency 1 cycle from capture).
REQ-014 SHALL implement FSM states EMPTY, FULL, RESUME.
REQ-015 EMPTY: id_valid_o=0, if_ready_o=1; on capture -> FULL.
REQ-016 FULL: hazard = ex_mem_read_i && ex_rd_i!=0 && (ex_rd_i==inst[19:15] || ex_rd_i==inst[24:20]).
REQ-017 FULL with hazard: id_valid_o=0, stall_o=1, if_ready_o=0, registers hold, next RESUME.
REQ-018 FULL without hazard, or RESUME (hazard check suppressed): id_valid_o=1, if_ready_o=ex_ready_i; ex_ready_i&&capture -> FULL with new instruction; ex_ready_i&&!capture -> EMPTY; !ex_ready_i -> hold contents, stay in (or go to) FULL.
REQ-019 SHALL give exactly one bubble cycle per load-use hazard.
REQ-020 flush_i SHALL have priority over every other event: next state EMPTY, id_inst_o=RESET_INST, imm_sel_o=000, a same-cycle fetch is dropped; if_ready_o unaffected combinationally.
REQ-021 stall_o SHALL be 0 in EMPTY and RESUME.

Reset
REQ-022 On rst_n_i=0, asynchronously: state EMPTY, id_valid_o=0, id_inst_o=RESET_INST, id_pc_o=0, imm_sel_o=000, stall_o=0; reset mid-stall discards the held instruction.
REQ-023 First capture SHALL be possible on the first rising edge after rst_n_i deasserts.

Configuration
REQ-024 Macro ID_HAZARD_DETECT_EN: defined -> REQ-016..REQ-019 active; undefined -> hazard is constant 0, RESUME unreachable, stall_o tied 0, ex_mem_read_i/ex_rd_i ignored.

Structure
REQ-025 Shared package SHALL hold the IMM_R..IMM_J 3-bit codes, opcode constants and the FSM state enum; the immediate generator uses the same codes.
REQ-026 Opcode-to-imm_sel decode SHALL be one combinational sub-module, imm_sel_dec; everything else in id_stage_ctrl.

Verification
REQ-027 Reset then feed 32'h00500093 (addi x1,x0,5), ex_ready_i=1 -> next cycle id_valid_o=1, imm_sel_o=001, id_pc_o=fed PC.
REQ-028 Feed 32'h00209113 (slli), 32'h00112023 (sw), 32'hFE0008E3 (beq), 32'h000010B7 (lui), 32'h008000EF (jal) -> imm_sel_o 010,011,100,101,110 in order.
REQ-029 FULL with 32'h002081B3 (add x3,x1,x2), ex_mem_read_i=1, ex_rd_i=2 -> one cycle id_valid_o=0, stall_o=1, if_ready_o=0; next cycle id_valid_o=1 with same instruction; repeat with ex_rd_i=0 -> no stall.
REQ-030 ex_ready_i=0 for 3 cycles while FULL -> id_inst_o stable, if_ready_o=0; release -> next instruction accepted.
REQ-031 flush_i=1 with if_valid_i=1 same cycle -> next cycle id_valid_o=0, id_inst_o=32'h00000013, fetched instruction not seen.
REQ-032 Assert rst_n_i=0 mid-cycle during stall -> outputs clear immediately, before next clock edge.
